frac_rate_counter_cascade: RTL

Parametrised successor to the fixed 16-bit fractional-rate counter/comparator. The block is a cascade of STAGES counter stages, each STAGE_W bits wide, with ripple-enable carry between stages, and a magnitude comparator against a programmable rate word C. It emits one Z pulse per enabled cycle while the pre-increment count is below C, so Z fires exactly C times per 2^N enabled cycles (N = STAGES*STAGE_W). Beyond the fixed predecessor, it adds a synchronous load, a saturate/wrap mode, a terminal-count pulse and a readable count.

---
 rtl/frac_rate_counter_cascade.sv | 99 +++++++++
 1 files changed

// File: rtl/frac_rate_counter_cascade.sv
// Cascaded ripple-enable counter with a rate comparator: Z fires C times per 2^N enabled cycles.
// Optional macro ZPIPE_EN adds one output register stage on Z/TC (latency 2 instead of 1).
module frac_rate_counter_cascade #(
  parameter int STAGES      = 4,
  parameter int STAGE_W     = 4,
  parameter int SAT_DEFAULT = 0
) (
  input  logic                       CK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic                       LOAD,
  input  logic [STAGES*STAGE_W-1:0]  LOAD_VAL,
  input  logic [STAGES*STAGE_W-1:0]  C,
  input  logic                       MODE_SAT,
  output logic                       Z,
  output logic                       TC,
  output logic [STAGES*STAGE_W-1:0]  COUNT
);

  localparam int N = STAGES * STAGE_W;

  if (STAGES < 1 || STAGE_W < 1 || SAT_DEFAULT < 0 || SAT_DEFAULT > 1) begin : g_param_check
    $error("frac_rate_counter_cascade: STAGES/STAGE_W must be >=1 and SAT_DEFAULT 0 or 1");
  end

  logic [STAGES-1:0] stage_inc;
  logic [STAGES-1:0] stage_ones;
  logic [N-1:0]      count_inc;
  logic [N-1:0]      count_nxt;
  logic              at_max;
  logic              z_nxt;
  logic              tc_nxt;

  // Stage k steps only when every stage below it is all-ones, so the chain is the carry.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign stage_ones[k] = &COUNT[k*STAGE_W +: STAGE_W];
    if (k == 0) begin : g_first
      assign stage_inc[k] = EN;
    end else begin : g_rest
      assign stage_inc[k] = stage_inc[k-1] & stage_ones[k-1];
    end
    assign count_inc[k*STAGE_W +: STAGE_W] =
      COUNT[k*STAGE_W +: STAGE_W] + STAGE_W'(stage_inc[k]);
  end

  assign at_max = &stage_ones;

  always_comb begin
    count_nxt = COUNT;
    z_nxt     = 1'b0;
    tc_nxt    = 1'b0;
    if (LOAD) begin
      count_nxt = LOAD_VAL;
    end else if (EN) begin
      // Compare uses the pre-update count so C=0 never fires and C=max misses only COUNT=max.
      z_nxt     = (COUNT < C);
      tc_nxt    = at_max;
      count_nxt = (at_max && MODE_SAT) ? COUNT : count_inc;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      COUNT <= '0;
    end else begin
      COUNT <= count_nxt;
    end
  end

`ifdef ZPIPE_EN
  logic z_main;
  logic tc_main;

  always_ff @(posedge CK) begin
    if (RST) begin
      z_main  <= 1'b0;
      tc_main <= 1'b0;
      Z       <= 1'b0;
      TC      <= 1'b0;
    end else begin
      z_main  <= z_nxt;
      tc_main <= tc_nxt;
      Z       <= z_main;
      TC      <= tc_main;
    end
  end
`else
  always_ff @(posedge CK) begin
    if (RST) begin
      Z  <= 1'b0;
      TC <= 1'b0;
    end else begin
      Z  <= z_nxt;
      TC <= tc_nxt;
    end
  end
`endif

endmodule
